// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared condition codes, flag indices and EX control bundle
//
// Purpose : types shared by the ID/EX register, the condition checker and
//           later-stage predication logic.
// Contents: cond_t      ARM condition field encodings (EQ..AL, NV)
//           FLAG_*      bit positions of N, Z, C, V inside a {N,Z,C,V} nibble
//           ctrl_e_t    registered single-bit control plus condition/flag-write
//           CTRL_BUBBLE value loaded into EX on a flush
package cpu_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic       valid;
      cond_t      cond;
      logic       pcs;
      logic       reg_w;
      logic       mem_w;
      logic       mem_to_reg;
      logic       branch;
      logic       alu_src;
      logic [1:0] flag_w;
   } ctrl_e_t;

   // A bubble carries AL so it is harmless even if valid were ignored.
   localparam ctrl_e_t CTRL_BUBBLE = '{
      valid:      1'b0,
      cond:       AL,
      pcs:        1'b0,
      reg_w:      1'b0,
      mem_w:      1'b0,
      mem_to_reg: 1'b0,
      branch:     1'b0,
      alu_src:    1'b0,
      flag_w:     2'b00
   };

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-field evaluator
//
// Purpose : decides whether an instruction with condition field cond executes
//           given the NZCV flags it observes.
// Ports   : cond    in  4  condition field
//           flags   in  4  {N,Z,C,V}
//           condmet out 1  condition satisfied (NV never satisfied)
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       condmet
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      condmet = 1'b0;
      case (cond_t'(cond))
         EQ: condmet = z;
         NE: condmet = ~z;
         CS: condmet = c;
         CC: condmet = ~c;
         MI: condmet = n;
         PL: condmet = ~n;
         VS: condmet = v;
         VC: condmet = ~v;
         HI: condmet = c & ~z;
         LS: condmet = ~c | z;
         GE: condmet = (n == v);
         LT: condmet = (n != v);
         GT: condmet = ~z & (n == v);
         LE: condmet = z | (n != v);
         AL: condmet = 1'b1;
         NV: condmet = 1'b0;
         default: condmet = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_ex_cond_stage.sv
// rtl/id_ex_cond_stage.sv - ID/EX control register, conditional execution and NZCV flags
//
// Purpose : registers the decoded control bundle into EX, evaluates the
//           instruction's condition against the architectural flags, gates the
//           side-effecting controls and updates NZCV from the ALU.
// Config  : ID_EX_FLAG_BYPASS_EN - when defined, the condition input merges a
//           one-entry registered copy of the last flag write into flags_q.
// Ports   : clk, rst                      clock, async active-high reset
//           valid_d .. wa3_d              decoded ID-stage control
//           stall_e, flush_e              hold EX / load a bubble (flush wins)
//           alu_flags_e                   ALU {N,Z,C,V} for the EX instruction
//           pcsrc_e, branch_taken_e,
//           reg_write_e, mem_write_e      controls gated by cond_ex_e
//           mem_to_reg_e, alu_src_e,
//           alu_control_e, wa3_e          registered copies
//           cond_ex_e                     instruction valid and condition met
//           flags_q                       architectural NZCV
module id_ex_cond_stage
   import cpu_pkg::*;
#(
   parameter int WA_W   = 4,
   parameter int ALUC_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic [3:0]        cond_d,
   input  logic              pcs_d,
   input  logic              reg_w_d,
   input  logic              mem_w_d,
   input  logic              mem_to_reg_d,
   input  logic              branch_d,
   input  logic              alu_src_d,
   input  logic [ALUC_W-1:0] alu_control_d,
   input  logic [1:0]        flag_w_d,
   input  logic [WA_W-1:0]   wa3_d,
   input  logic              stall_e,
   input  logic              flush_e,
   input  logic [3:0]        alu_flags_e,
   output logic              pcsrc_e,
   output logic              branch_taken_e,
   output logic              reg_write_e,
   output logic              mem_write_e,
   output logic              mem_to_reg_e,
   output logic              alu_src_e,
   output logic [ALUC_W-1:0] alu_control_e,
   output logic [WA_W-1:0]   wa3_e,
   output logic              cond_ex_e,
   output logic [3:0]        flags_q
);

   ctrl_e_t           ctrl_e;
   logic [ALUC_W-1:0] alu_control_q;
   logic [WA_W-1:0]   wa3_q;
   logic [3:0]        flags_eff;
   logic [3:0]        flag_mask;
   logic              condmet;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_e        <= '0;
         alu_control_q <= '0;
         wa3_q         <= '0;
      end else if (flush_e) begin
         ctrl_e        <= CTRL_BUBBLE;
         alu_control_q <= '0;
         wa3_q         <= '0;
      end else if (!stall_e) begin
         ctrl_e.valid      <= valid_d;
         ctrl_e.cond       <= cond_t'(cond_d);
         ctrl_e.pcs        <= pcs_d;
         ctrl_e.reg_w      <= reg_w_d;
         ctrl_e.mem_w      <= mem_w_d;
         ctrl_e.mem_to_reg <= mem_to_reg_d;
         ctrl_e.branch     <= branch_d;
         ctrl_e.alu_src    <= alu_src_d;
         ctrl_e.flag_w     <= flag_w_d;
         alu_control_q     <= alu_control_d;
         wa3_q             <= wa3_d;
      end
   end

   // A held instruction must not write until it actually leaves EX, so the
   // write is qualified by !stall_e; flush_e only affects the incoming slot.
   assign flag_mask = {{2{ctrl_e.flag_w[1]}}, {2{ctrl_e.flag_w[0]}}}
                      & {4{cond_ex_e & ~stall_e}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= (flags_q & ~flag_mask) | (alu_flags_e & flag_mask);
      end
   end

`ifdef ID_EX_FLAG_BYPASS_EN
   logic [3:0] byp_val;
   logic [3:0] byp_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byp_val  <= 4'b0000;
         byp_mask <= 4'b0000;
      end else begin
         byp_val  <= alu_flags_e;
         byp_mask <= flag_mask;
      end
   end

   assign flags_eff = (flags_q & ~byp_mask) | (byp_val & byp_mask);
`else
   assign flags_eff = flags_q;
`endif

   cond_check u_cond_check (
      .cond    (ctrl_e.cond),
      .flags   (flags_eff),
      .condmet (condmet)
   );

   assign cond_ex_e      = ctrl_e.valid & condmet;
   assign pcsrc_e        = ctrl_e.pcs    & cond_ex_e;
   assign branch_taken_e = ctrl_e.branch & cond_ex_e;
   assign reg_write_e    = ctrl_e.reg_w  & cond_ex_e;
   assign mem_write_e    = ctrl_e.mem_w  & cond_ex_e;
   assign mem_to_reg_e   = ctrl_e.mem_to_reg;
   assign alu_src_e      = ctrl_e.alu_src;
   assign alu_control_e  = alu_control_q;
   assign wa3_e          = wa3_q;

endmodule

// File: tb/tb_id_ex_cond_stage.sv
// tb/tb_id_ex_cond_stage.sv - self-checking bench for id_ex_cond_stage
module tb_id_ex_cond_stage;

   typedef struct packed {
      bit       valid;
      bit [3:0] cond;
      bit       pcs;
      bit       regw;
      bit       memw;
      bit       m2r;
      bit       branch;
      bit       alusrc;
      bit [2:0] aluc;
      bit [1:0] fw;
      bit [3:0] wa3;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       stall_e = 1'b0;
   logic       flush_e = 1'b0;
   logic [3:0] alu_flags_e = 4'b0000;
   instr_t     id_in = '0;

   logic       pcsrc_e, branch_taken_e, reg_write_e, mem_write_e;
   logic       mem_to_reg_e, alu_src_e, cond_ex_e;
   logic [2:0] alu_control_e;
   logic [3:0] wa3_e;
   logic [3:0] flags_q;

   instr_t     m_ex;
   bit [3:0]   m_flags;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_ex_cond_stage #(.WA_W(4), .ALUC_W(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_d        (id_in.valid),
      .cond_d         (id_in.cond),
      .pcs_d          (id_in.pcs),
      .reg_w_d        (id_in.regw),
      .mem_w_d        (id_in.memw),
      .mem_to_reg_d   (id_in.m2r),
      .branch_d       (id_in.branch),
      .alu_src_d      (id_in.alusrc),
      .alu_control_d  (id_in.aluc),
      .flag_w_d       (id_in.fw),
      .wa3_d          (id_in.wa3),
      .stall_e        (stall_e),
      .flush_e        (flush_e),
      .alu_flags_e    (alu_flags_e),
      .pcsrc_e        (pcsrc_e),
      .branch_taken_e (branch_taken_e),
      .reg_write_e    (reg_write_e),
      .mem_write_e    (mem_write_e),
      .mem_to_reg_e   (mem_to_reg_e),
      .alu_src_e      (alu_src_e),
      .alu_control_e  (alu_control_e),
      .wa3_e          (wa3_e),
      .cond_ex_e      (cond_ex_e),
      .flags_q        (flags_q)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Even codes test a base predicate, the odd partner is its negation;
   // 1110/1111 are the always/never pair outside that rule.
   function automatic bit cond_ok(bit [3:0] c, bit [3:0] f);
      bit base;
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: base = f[2];
         3'd1: base = f[1];
         3'd2: base = f[3];
         3'd3: base = f[0];
         3'd4: base = f[1] && !f[2];
         3'd5: base = (f[3] == f[0]);
         default: base = !f[2] && (f[3] == f[0]);
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic instr_t mk(bit v, bit [3:0] c, bit pcs, bit regw, bit memw,
                                 bit br, bit [1:0] fw);
      instr_t r = '0;
      r.valid = v; r.cond = c; r.pcs = pcs; r.regw = regw;
      r.memw = memw; r.branch = br; r.fw = fw;
      return r;
   endfunction

   function automatic instr_t rand_instr();
      instr_t r;
      r = instr_t'($urandom);
      r.valid = ($urandom_range(0, 3) != 0);
      return r;
   endfunction

   task automatic model_reset();
      m_ex = '0;
      m_flags = 4'b0000;
   endtask

   task automatic compare_model();
      bit ex;
      ex = m_ex.valid && cond_ok(m_ex.cond, m_flags);
      check("gated", {pcsrc_e, branch_taken_e, reg_write_e, mem_write_e, cond_ex_e},
            {m_ex.pcs && ex, m_ex.branch && ex, m_ex.regw && ex, m_ex.memw && ex, ex});
      check("copy", {mem_to_reg_e, alu_src_e, alu_control_e, wa3_e},
            {m_ex.m2r, m_ex.alusrc, m_ex.aluc, m_ex.wa3});
      check("flags", flags_q, m_flags);
   endtask

   task automatic step_model();
      bit ex;
      ex = m_ex.valid && cond_ok(m_ex.cond, m_flags);
      if (ex && !stall_e) begin
         if (m_ex.fw[1]) m_flags[3:2] = alu_flags_e[3:2];
         if (m_ex.fw[0]) m_flags[1:0] = alu_flags_e[1:0];
      end
      if (flush_e) m_ex = mk(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      else if (!stall_e) m_ex = id_in;
   endtask

   // Compare on the falling edge, advance the model, then return just after
   // the next rising edge so the caller can drive new inputs.
   task automatic tick();
      @(negedge clk);
      compare_model();
      step_model();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [17:0] all_outs();
      return {pcsrc_e, branch_taken_e, reg_write_e, mem_write_e, mem_to_reg_e,
              alu_src_e, alu_control_e, wa3_e, cond_ex_e, flags_q};
   endfunction

   initial begin
      // Reset with arbitrary inputs
      id_in = rand_instr();
      alu_flags_e = 4'($urandom);
      stall_e = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_all", all_outs(), 18'd0);
      model_reset();
      rst = 1'b0;
      stall_e = 1'b0;

      // First instruction after reset
      id_in = mk(1, 4'hE, 0, 1, 0, 0, 2'b00);
      tick();
      check("rst_first_regw", reg_write_e, 1'b1);

      // CMP equal, then BEQ, then BNE
      id_in = mk(1, 4'hE, 0, 0, 0, 0, 2'b11);
      tick();
      alu_flags_e = 4'b0100;
      id_in = mk(1, 4'h0, 1, 0, 0, 1, 2'b00);
      tick();
      check("cmp_flags", flags_q, 4'b0100);
      check("beq_pcsrc", pcsrc_e, 1'b1);
      check("beq_branch", branch_taken_e, 1'b1);
      id_in = mk(1, 4'h1, 1, 0, 0, 1, 2'b00);
      tick();
      check("bne_pcsrc", pcsrc_e, 1'b0);

      // Partial flag write
      id_in = mk(1, 4'hE, 0, 0, 0, 0, 2'b11);
      tick();
      alu_flags_e = 4'b1111;
      id_in = mk(1, 4'hE, 0, 0, 0, 0, 2'b10);
      tick();
      check("flags_all_set", flags_q, 4'b1111);
      alu_flags_e = 4'b0000;
      id_in = mk(0, 4'h0, 0, 0, 0, 0, 2'b00);
      tick();
      check("partial_nz", flags_q, 4'b0011);

      // Failed condition: no store, no flag update
      id_in = mk(1, 4'hE, 0, 0, 0, 0, 2'b11);
      tick();
      alu_flags_e = 4'b0000;
      id_in = mk(1, 4'h0, 0, 0, 1, 0, 2'b11);
      tick();
      check("str_memw", mem_write_e, 1'b0);
      check("str_condex", cond_ex_e, 1'b0);
      alu_flags_e = 4'b1111;
      id_in = mk(0, 4'h0, 0, 0, 0, 0, 2'b00);
      tick();
      check("str_noflag", flags_q, 4'b0000);

      // Stall for three cycles: flags written once, on leaving EX
      id_in = mk(1, 4'hE, 0, 0, 0, 0, 2'b11);
      tick();
      stall_e = 1'b1;
      alu_flags_e = 4'b1010;
      id_in = mk(1, 4'hE, 0, 1, 0, 0, 2'b00);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold_flags", flags_q, 4'b0000);
      end
      stall_e = 1'b0;
      tick();
      check("stall_release_flags", flags_q, 4'b1010);

      // Flush overrides stall
      id_in = mk(1, 4'hE, 1, 1, 1, 1, 2'b00);
      tick();
      flush_e = 1'b1;
      stall_e = 1'b1;
      tick();
      check("flush_gated", {pcsrc_e, branch_taken_e, reg_write_e, mem_write_e, cond_ex_e}, 5'd0);
      flush_e = 1'b0;
      stall_e = 1'b0;

      // Reserved condition never executes
      id_in = mk(1, 4'hF, 0, 1, 0, 0, 2'b00);
      tick();
      check("nv_condex", cond_ex_e, 1'b0);

      // Randomised run with an asynchronous reset in the middle
      for (int i = 0; i < 400; i++) begin
         id_in = rand_instr();
         alu_flags_e = 4'($urandom);
         stall_e = ($urandom_range(0, 5) == 0);
         flush_e = ($urandom_range(0, 6) == 0);
         if (i == 200) begin
            #2 rst = 1'b1;
            #1 check("async_reset", all_outs(), 18'd0);
            model_reset();
            @(posedge clk);
            #1 rst = 1'b0;
         end else begin
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
